transmissor_16: RTL and testbench

// - Serializes one 16-bit word as two consecutive UART frames, high byte first, then low byte.
// - Upstream end of the 16-bit serial link: its line output feeds the 16-bit receiver datapath,

---
 rtl/transmissor_16_pkg.sv | 20 ++
 rtl/transmissor_16_tx_serial_8.sv | 62 ++++++
 rtl/transmissor_16.sv | 97 +++++++++
 tb/tb_transmissor_16.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/transmissor_16_pkg.sv
// transmissor_16_pkg: FSM state codes and bit/frame timing helpers shared by both ends of the 16-bit serial link.
package transmissor_16_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        ENVIA_ALTO  = 4'd1,
        INTERVALO   = 4'd2,
        ENVIA_BAIXO = 4'd3,
        FIM         = 4'd4
    } estado_t;

    function automatic int bit_ticks(input int clock_hz, input int baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic int frame_bits(input int n_bits, input int parity);
        return n_bits + 2 + parity;
    endfunction

endpackage

// File: rtl/transmissor_16_tx_serial_8.sv
// tx_serial_8: byte-level UART transmitter; start, 8 data bits LSB first, optional even parity, stop.
module tx_serial_8
    import transmissor_16_pkg::*;
#(
    parameter int BAUD_RATE = 115200,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       saida,
    output logic       fim
);

    localparam int T  = bit_ticks(CLOCK_HZ, BAUD_RATE);
    localparam int F  = frame_bits(N_BITS, PARITY);
    localparam int TW = $clog2(T + 1);

    logic          busy_q;
    logic [TW-1:0] tick_q;
    logic [3:0]    bit_q;
    logic [9:0]    frame_q;
    logic          saida_q;
    logic          last_tick;
    logic          last_bit;

    assign last_tick = tick_q == TW'(T - 1);
    assign last_bit  = bit_q == 4'(F - 1);
    assign fim       = busy_q && last_tick && last_bit;
    assign saida     = saida_q;

    // A new byte may start on the same edge the previous stop bit ends, so frames chain with no gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            saida_q <= 1'b1;
        end else if (partida && (!busy_q || fim)) begin
            busy_q  <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            frame_q <= PARITY != 0 ? {1'b1, ^dado, dado} : {2'b11, dado};
            saida_q <= 1'b0;
        end else if (busy_q) begin
            if (!last_tick) begin
                tick_q <= tick_q + 1'b1;
            end else begin
                tick_q  <= '0;
                bit_q   <= last_bit ? '0 : bit_q + 1'b1;
                busy_q  <= !last_bit;
                saida_q <= last_bit ? 1'b1 : frame_q[0];
                frame_q <= {1'b1, frame_q[9:1]};
            end
        end
    end

endmodule

// File: rtl/transmissor_16.sv
// transmissor_16: sends a 16-bit word as two UART frames, high byte first, with an idle gap between them.
module transmissor_16
    import transmissor_16_pkg::*;
#(
    parameter int BAUD_RATE = 115200,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 1,
    parameter int GAP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar,
    input  logic [15:0] data_in,
    output logic        tx_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    localparam int GAP_CYC = GAP_BITS * bit_ticks(CLOCK_HZ, BAUD_RATE);

    estado_t     estado_q;
    logic [7:0]  baixo_q;
    logic [15:0] gap_q;
    logic        ocupado_q;
    logic        pronto_q;
    logic        partida;
    logic        fim_byte;
    logic        gap_fim;
    logic [7:0]  byte_sel;

    // The high byte goes straight from data_in into the transmitter on the accept edge; only the low byte is held here.
    assign gap_fim  = gap_q == 16'(GAP_CYC - 1);
    assign byte_sel = estado_q == INICIAL ? data_in[15:8] : baixo_q;

    always_comb begin
        partida = (estado_q == INICIAL && enviar)
               || (estado_q == ENVIA_ALTO && fim_byte && GAP_CYC == 0)
               || (estado_q == INTERVALO && gap_fim);
    end

    tx_serial_8 #(
        .BAUD_RATE(BAUD_RATE),
        .CLOCK_HZ (CLOCK_HZ),
        .N_BITS   (N_BITS),
        .PARITY   (PARITY)
    ) u_tx (
        .clock  (clock),
        .reset  (reset),
        .partida(partida),
        .dado   (byte_sel),
        .saida  (tx_serial),
        .fim    (fim_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            baixo_q   <= '0;
            gap_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                INICIAL: if (enviar) begin
                    baixo_q   <= data_in[7:0];
                    ocupado_q <= 1'b1;
                    estado_q  <= ENVIA_ALTO;
                end
                ENVIA_ALTO: if (fim_byte) begin
                    gap_q    <= '0;
                    estado_q <= GAP_CYC == 0 ? ENVIA_BAIXO : INTERVALO;
                end
                INTERVALO: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_fim) estado_q <= ENVIA_BAIXO;
                end
                ENVIA_BAIXO: if (fim_byte) begin
                    pronto_q <= 1'b1;
                    estado_q <= FIM;
                end
                FIM: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= INICIAL;
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_transmissor_16.sv
// tb_transmissor_16: directed words on two configurations, line decoded by monitors against a queue of expected frames.
module tb_transmissor_16;

    localparam int T = 8;

    typedef struct {int line; logic [10:0] frame; int start;} fr_t;
    typedef struct {int line; int at;} pr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  en = '0;
    logic [1:0]  tx, ocu, pr;
    logic [15:0] din_a = '0, din_b = '0;
    logic [3:0]  db_a, db_b;
    int          cyc = 0, errors = 0, checks = 0;
    int          np [2] = '{0, 0};
    fr_t         fq[$];
    pr_t         pq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    transmissor_16 #(.BAUD_RATE(100), .CLOCK_HZ(800), .N_BITS(8), .PARITY(1), .GAP_BITS(1)) dut_a (
        .clock(clk), .reset(rst), .enviar(en[0]), .data_in(din_a),
        .tx_serial(tx[0]), .ocupado(ocu[0]), .pronto(pr[0]), .db_estado(db_a)
    );

    transmissor_16 #(.BAUD_RATE(100), .CLOCK_HZ(800), .N_BITS(8), .PARITY(0), .GAP_BITS(0)) dut_b (
        .clock(clk), .reset(rst), .enviar(en[1]), .data_in(din_b),
        .tx_serial(tx[1]), .ocupado(ocu[1]), .pronto(pr[1]), .db_estado(db_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] dbl(input int l);
        return l == 0 ? db_a : db_b;
    endfunction

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Frames are {stop, parity, d7..d0, start}; line 1 has no parity so its frame is 10 bits.
    task automatic start_word(input int l, input logic [15:0] d, input logic [10:0] fh, input logic [10:0] fl,
                              input bit push, output int acc);
        int f, g;
        f = l == 0 ? 11 : 10;
        g = l == 0 ? 1 : 0;
        @(negedge clk);
        en[l] = 1'b1;
        if (l == 0) din_a = d; else din_b = d;
        @(negedge clk);
        en[l] = 1'b0;
        acc = cyc;
        if (push) begin
            fq.push_back(fr_t'{l, fh, acc});
            fq.push_back(fr_t'{l, fl, acc + (f + g) * T});
            pq.push_back(pr_t'{l, acc + (2 * f + g) * T});
        end
    endtask

    task automatic finish_word(input int l);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = pr[l];
        end
        chk("pronto_seen", 32'(seen), 1);
        if (seen) begin
            chk("ocupado_at_pronto", 32'(ocu[l]), 1);
            chk("estado_at_pronto", 32'(dbl(l)), 4);
            @(negedge clk);
            chk("pronto_width", 32'(pr[l]), 0);
            chk("ocupado_after_pronto", 32'(ocu[l]), 0);
            chk("estado_after_pronto", 32'(dbl(l)), 0);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int F = g == 0 ? 11 : 10;

        initial begin : rx
            logic        prev;
            logic [10:0] bits;
            bit          stable, ab;
            int          st;
            fr_t         e;
            prev = 1'b1;
            forever begin
                @(negedge clk);
                if (!rst && prev === 1'b1 && tx[g] === 1'b0) begin
                    st = cyc;
                    bits = '0;
                    stable = 1'b1;
                    ab = 1'b0;
                    for (int b = 0; b < F; b++) begin
                        for (int k = 0; k < T; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (rst) ab = 1'b1;
                            if (k == 0) bits[b] = tx[g];
                            else if (tx[g] !== bits[b]) stable = 1'b0;
                        end
                    end
                    if (!ab) begin
                        if (fq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame line %0d: got %0h expected none at cycle %0d", g, bits, st);
                        end else begin
                            e = fq.pop_front();
                            chk("frame_line", g, e.line);
                            chk("frame_bits", 32'(bits), 32'(e.frame));
                            chk("frame_start", st, e.start);
                            chk("bit_stable", 32'(stable), 1);
                        end
                    end
                end
                prev = tx[g];
            end
        end

        initial begin : pm
            pr_t e;
            forever begin
                @(negedge clk);
                if (pr[g] === 1'b1) begin
                    np[g]++;
                    if (pq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pronto line %0d: got pulse expected none at cycle %0d", g, cyc);
                    end else begin
                        e = pq.pop_front();
                        chk("pronto_line", g, e.line);
                        chk("pronto_cycle", cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin : main
        int acc, n0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_a", 32'(tx[0]), 1);
        chk("rst_tx_b", 32'(tx[1]), 1);
        chk("rst_ocupado", 32'(ocu), 0);
        chk("rst_pronto", 32'(pr), 0);
        chk("rst_estado_a", 32'(db_a), 0);
        chk("rst_estado_b", 32'(db_b), 0);
        rst = 1'b0;

        start_word(0, 16'hA53C, 11'h54A, 11'h478, 1'b1, acc);
        chk("cycle1_estado", 32'(db_a), 1);
        chk("cycle1_ocupado", 32'(ocu[0]), 1);
        chk("cycle1_tx", 32'(tx[0]), 0);
        at(acc + 90);
        chk("gap_estado", 32'(db_a), 2);
        chk("gap_tx", 32'(tx[0]), 1);
        at(acc + 100);
        chk("baixo_estado", 32'(db_a), 3);
        finish_word(0);

        start_word(0, 16'h0180, 11'h602, 11'h700, 1'b1, acc);
        finish_word(0);

        start_word(1, 16'hFFFF, 11'h3FE, 11'h3FE, 1'b1, acc);
        finish_word(1);

        start_word(0, 16'hA53C, 11'h54A, 11'h478, 1'b1, acc);
        at(acc + 120);
        en[0] = 1'b1;
        din_a = 16'h1234;
        @(negedge clk);
        en[0] = 1'b0;
        finish_word(0);
        repeat (200) @(negedge clk);
        chk("ignored_enviar_ocupado", 32'(ocu[0]), 0);
        chk("ignored_enviar_queue", fq.size(), 0);

        start_word(0, 16'h5555, 11'h0, 11'h0, 1'b0, acc);
        at(acc + 39);
        chk("pre_reset_tx", 32'(tx[0]), 0);
        n0 = np[0];
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx[0]), 1);
        chk("async_rst_ocupado", 32'(ocu[0]), 0);
        chk("async_rst_estado", 32'(db_a), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (250) @(negedge clk);
        chk("no_pronto_after_reset", np[0], n0);
        start_word(0, 16'h00FF, 11'h400, 11'h5FE, 1'b1, acc);
        finish_word(0);

        @(negedge clk);
        en[0] = 1'b1;
        din_a = 16'h5A5A;
        @(negedge clk);
        acc = cyc;
        fq.push_back(fr_t'{0, 11'h4B4, acc});
        fq.push_back(fr_t'{0, 11'h4B4, acc + 96});
        fq.push_back(fr_t'{0, 11'h4B4, acc + 186});
        fq.push_back(fr_t'{0, 11'h4B4, acc + 282});
        pq.push_back(pr_t'{0, acc + 184});
        pq.push_back(pr_t'{0, acc + 370});
        finish_word(0);
        at(acc + 190);
        en[0] = 1'b0;
        finish_word(0);
        repeat (20) @(negedge clk);
        chk("frames_left", fq.size(), 0);
        chk("prontos_left", pq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
